// File: rtl/paced_fifo.sv
// Synchronous FIFO paced by divided write/read clocks sampled in the clk domain.
// Each rising edge of w_clk / r_clk opens one write / read slot; overflow and underflow are sticky.
module paced_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              w_clk,
    input  logic              r_clk,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    input  logic              clr_flags,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              w_q;
    logic              r_q;
    logic              wslot;
    logic              rslot;
    logic              push;
    logic              push_rej;
    logic              pop;
    logic              pop_rej;

    assign wslot = w_clk & ~w_q;
    assign rslot = r_clk & ~r_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign count = wptr - rptr;

    assign push     = wslot & wr_req & ~full;
    assign push_rej = wslot & wr_req & full;
    assign pop      = rslot & ~empty;
    assign pop_rej  = rslot & empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q       <= 1'b0;
            r_q       <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            wr_ack    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            w_q      <= w_clk;
            r_q      <= r_clk;
            wr_ack   <= push;
            rd_valid <= pop;
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr    <= rptr + PTR_ONE;
                rd_data <= mem[rptr[ADDR_W-1:0]];
            end
            // A new event in the same cycle as clr_flags keeps the flag set.
            overflow  <= push_rej | (overflow & ~clr_flags);
            underflow <= pop_rej | (underflow & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_paced_fifo.sv
// Self-checking bench for paced_fifo: directed test-plan steps plus a random phase,
// all compared every cycle against a queue-based reference model.
module tb_paced_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              w_clk = 1'b0;
    logic              r_clk = 1'b0;
    logic              wr_req = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              clr_flags = 1'b0;
    logic              wr_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: FIFO contents as a queue plus flags and output registers.
    byte unsigned mq[$];
    byte unsigned src[$];
    byte unsigned outq[$];
    logic         m_wq = 1'b0, m_rq = 1'b0, m_ack = 1'b0, m_rv = 1'b0;
    logic         m_ovf = 1'b0, m_unf = 1'b0;
    logic [7:0]   m_rd = 8'h00;
    bit           pace_w = 0, pace_r = 0;
    int           wcnt = 0, rcnt = 0, rv_seen = 0;
    logic         done;

    paced_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .w_clk     (w_clk),
        .r_clk     (r_clk),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .clr_flags (clr_flags),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), mq.size());
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("wr_ack", 32'(wr_ack), 32'(m_ack));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_wq = 1'b0; m_rq = 1'b0; m_ack = 1'b0; m_rv = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_rd = 8'h00;
    endtask

    task automatic drive_prod();
        wr_req = (src.size() > 0);
        if (src.size() > 0) wr_data = src[0];
    endtask

    task automatic load(input byte unsigned b);
        src.push_back(b);
        drive_prod();
    endtask

    // One clk cycle: advance the model on the edge, check every output, then drive next inputs.
    task automatic step();
        bit ws, rs, do_push, do_pop;
        int sz;
        @(posedge clk);
        ws = w_clk && !m_wq;
        rs = r_clk && !m_rq;
        sz = mq.size();
        do_push = ws && wr_req && (sz < DEPTH);
        do_pop  = rs && (sz > 0);
        if (clr_flags) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ws && wr_req && sz == DEPTH) m_ovf = 1'b1;
        if (rs && sz == 0) m_unf = 1'b1;
        m_ack = do_push;
        m_rv  = do_pop;
        if (do_pop) m_rd = mq.pop_front();
        if (do_push) mq.push_back(wr_data);
        m_wq = w_clk;
        m_rq = r_clk;
        #1;
        check_all();
        if (rd_valid) begin
            rv_seen++;
            outq.push_back(rd_data);
        end
        if (m_ack && src.size() > 0) void'(src.pop_front());
        if (pace_w) begin
            wcnt++;
            if (wcnt == 2) begin wcnt = 0; w_clk = ~w_clk; end
        end
        if (pace_r) begin
            rcnt++;
            if (rcnt == 3) begin rcnt = 0; r_clk = ~r_clk; end
        end
        drive_prod();
    endtask

    task automatic manual(input logic w, input logic r);
        w_clk = w; r_clk = r;
        step();
        w_clk = 1'b0; r_clk = 1'b0;
        step();
    endtask

    task automatic clr_pulse();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    initial begin
        // 1: reset state
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        check_all();

        // 2: single word through the FIFO
        pace_w = 1; pace_r = 1;
        load(8'hA5);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin step(); done = m_ack; end
        chk("t2_ack_seen", 32'(done), 1);
        chk("t2_count_after_ack", 32'(count), 1);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin step(); done = m_rv; end
        chk("t2_pop_seen", 32'(done), 1);
        chk("t2_rd_data", 32'(rd_data), 32'hA5);
        chk("t2_empty", 32'(empty), 1);

        // 3: fill with reads stalled, overflow, then drain in order
        pace_r = 0; r_clk = 1'b0;
        for (int i = 0; i < 9; i++) load(8'(i));
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin step(); done = (mq.size() == DEPTH); end
        chk("t3_fill_done", 32'(done), 1);
        chk("t3_full", 32'(full), 1);
        chk("t3_count8", 32'(count), 8);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin step(); done = m_ovf; end
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_count_still8", 32'(count), 8);
        src.delete(); drive_prod();
        rv_seen = 0; outq.delete();
        pace_r = 1; rcnt = 0;
        for (int i = 0; i < 200 && rv_seen < 8; i++) step();
        repeat (6) step();
        chk("t3_rd_valid_pulses", rv_seen, 8);
        chk("t3_out_len", outq.size(), 8);
        for (int i = 0; i < 8 && i < outq.size(); i++) chk("t3_order", 32'(outq[i]), i);

        // 4: underflow on empty FIFO, rd_data held, then clear
        pace_w = 0; w_clk = 1'b0;
        clr_pulse();
        rv_seen = 0;
        repeat (14) step();
        chk("t4_underflow", 32'(underflow), 1);
        chk("t4_no_rd_valid", rv_seen, 0);
        chk("t4_rd_data_held", 32'(rd_data), 32'h07);
        pace_r = 0; r_clk = 1'b0;
        step();
        clr_pulse();
        step();
        chk("t4_underflow_clr", 32'(underflow), 0);

        // 5: simultaneous write and read slots
        for (int i = 0; i < 16; i++) load(8'(8'h30 + i));
        repeat (3) manual(1'b1, 1'b0);
        chk("t5_count3_pre", 32'(count), 3);
        manual(1'b1, 1'b1);
        chk("t5_count3_both", 32'(count), 3);
        repeat (3) manual(1'b0, 1'b1);
        clr_pulse();
        chk("t5_empty_pre", 32'(empty), 1);
        manual(1'b1, 1'b1);
        chk("t5_count1_both", 32'(count), 1);
        chk("t5_underflow", 32'(underflow), 1);
        repeat (7) manual(1'b1, 1'b0);
        chk("t5_count8_pre", 32'(count), 8);
        clr_pulse();
        manual(1'b1, 1'b1);
        chk("t5_count7_both", 32'(count), 7);
        chk("t5_overflow", 32'(overflow), 1);

        // random phase: arbitrary pacing levels, flag clears and data
        for (int i = 0; i < 300; i++) begin
            w_clk = 1'($urandom_range(0, 1));
            r_clk = 1'($urandom_range(0, 1));
            clr_flags = ($urandom_range(0, 15) == 0);
            if (src.size() < 2) load(8'($urandom));
            step();
        end
        clr_flags = 1'b0;
        src.delete(); drive_prod();
        w_clk = 1'b0; r_clk = 1'b0;

        // 6: wrap-around ordering with both cadences running
        pace_r = 1; rcnt = 0;
        for (int i = 0; i < 200 && mq.size() > 0; i++) step();
        chk("t6_drained", 32'(empty), 1);
        outq.delete();
        for (int i = 0; i < 20; i++) load(8'(8'h10 + i));
        pace_w = 1; wcnt = 0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            step();
            done = (src.size() == 0) && (mq.size() == 0) && (outq.size() >= 20);
        end
        chk("t6_done", 32'(done), 1);
        chk("t6_out_len", outq.size(), 20);
        for (int i = 0; i < 20 && i < outq.size(); i++) chk("t6_order", 32'(outq[i]), 32'h10 + i);

        // asynchronous reset with five words held
        pace_r = 0; r_clk = 1'b0;
        for (int i = 0; i < 5; i++) load(8'(8'h50 + i));
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin step(); done = (mq.size() == 5); end
        chk("t6_count5", 32'(count), 5);
        pace_w = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_empty", 32'(empty), 1);
        chk("async_overflow", 32'(overflow), 0);
        chk("async_underflow", 32'(underflow), 0);
        chk("async_rd_data", 32'(rd_data), 0);
        reset_n = 1'b1;
        model_reset();
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
